control_unit: RTL and testbench

Two-state sequencer for the 4-bit CPU. It fetches 8-bit instructions from the ROM and decodes them. It then drives the program counter's `pc_inc`/`pc_load`/`pc_in` controls and the datapath write strobes. It executes one instruction every two cycles and parks in HALT on the HLT opcode.

---
 rtl/control_unit.sv | 129 ++++++++++++
 tb/tb_control_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Two-state instruction sequencer for the 4-bit CPU: FETCH latches the ROM byte into ir,
// EXECUTE decodes it into one-cycle PC and datapath strobes, HLT parks the unit in HALT.
module control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [7:0] instr,
   input  logic       zero_flag,
   input  logic       carry_flag,
   output logic       pc_inc,
   output logic       pc_load,
   output logic [3:0] pc_target,
   output logic       acc_we,
   output logic [1:0] alu_op,
   output logic [3:0] imm,
   output logic       out_we,
   output logic       halted,
   output logic [7:0] retired
);

   typedef enum logic [1:0] {
      StFetch,
      StExecute,
      StHalt
   } state_e;

   localparam logic [3:0] OpNop = 4'h0;
   localparam logic [3:0] OpLdi = 4'h1;
   localparam logic [3:0] OpAdd = 4'h2;
   localparam logic [3:0] OpSub = 4'h3;
   localparam logic [3:0] OpJmp = 4'h5;
   localparam logic [3:0] OpJz  = 4'h6;
   localparam logic [3:0] OpJc  = 4'h7;
   localparam logic [3:0] OpOut = 4'h8;
   localparam logic [3:0] OpHlt = 4'hF;

   localparam logic [1:0] AluPass = 2'b00;
   localparam logic [1:0] AluAdd  = 2'b01;
   localparam logic [1:0] AluSub  = 2'b10;

   state_e     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] retired_q, retired_d;
   logic [3:0] opcode;

   assign opcode = ir_q[7:4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StFetch;
         ir_q      <= 8'h00;
         retired_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      unique case (state_q)
         StFetch: begin
            if (run) begin
               ir_d    = instr;
               state_d = StExecute;
            end
         end
         StExecute: begin
            // run is deliberately ignored here so a started instruction always completes
            if (retired_q != 8'hFF) retired_d = retired_q + 8'd1;
            state_d = (opcode == OpHlt) ? StHalt : StFetch;
         end
         StHalt: state_d = StHalt;
         default: state_d = StFetch;
      endcase
   end

   always_comb begin
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      acc_we  = 1'b0;
      alu_op  = AluAdd;
      out_we  = 1'b0;
      if (state_q == StExecute) begin
         case (opcode)
            OpNop: pc_inc = 1'b1;
            OpLdi: begin
               acc_we = 1'b1;
               alu_op = AluPass;
               pc_inc = 1'b1;
            end
            OpAdd: begin
               acc_we = 1'b1;
               alu_op = AluAdd;
               pc_inc = 1'b1;
            end
            OpSub: begin
               acc_we = 1'b1;
               alu_op = AluSub;
               pc_inc = 1'b1;
            end
            OpJmp: pc_load = 1'b1;
            OpJz: begin
               pc_load = zero_flag;
               pc_inc  = ~zero_flag;
            end
            OpJc: begin
               pc_load = carry_flag;
               pc_inc  = ~carry_flag;
            end
            OpOut: begin
               out_we = 1'b1;
               pc_inc = 1'b1;
            end
            OpHlt: ;
            default: pc_inc = 1'b1;
         endcase
      end
   end

   assign pc_target = ir_q[3:0];
   assign imm       = ir_q[3:0];
   assign halted    = (state_q == StHalt);
   assign retired   = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a stimulus process pushes the expected per-cycle outputs of
// an instruction-level CPU model; a monitor pops and compares them on the falling edge.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic [7:0] instr = 8'h00;
   logic       zero_flag = 1'b0;
   logic       carry_flag = 1'b0;
   logic       pc_inc, pc_load, acc_we, out_we, halted;
   logic [3:0] pc_target, imm;
   logic [1:0] alu_op;
   logic [7:0] retired;

   control_unit dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .instr     (instr),
      .zero_flag (zero_flag),
      .carry_flag(carry_flag),
      .pc_inc    (pc_inc),
      .pc_load   (pc_load),
      .pc_target (pc_target),
      .acc_we    (acc_we),
      .alu_op    (alu_op),
      .imm       (imm),
      .out_we    (out_we),
      .halted    (halted),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_inc;
      logic       pc_load;
      logic [3:0] pc_target;
      logic       acc_we;
      logic [1:0] alu_op;
      logic [3:0] imm;
      logic       out_we;
      logic       halted;
      logic [7:0] retired;
   } obs_t;

   obs_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   n_inc = 0;
   int   cyc = 0;

   // Instruction-level model: a held instruction waiting to execute, a halt flag, a count.
   logic       m_busy = 1'b0;
   logic       m_halt = 1'b0;
   logic [7:0] m_ir = 8'h00;
   int         m_ret = 0;
   logic [3:0] pc = 4'h0;
   logic [7:0] rom[16];

   function automatic obs_t model_out(input logic z, input logic c);
      obs_t e;
      e = '0;
      e.alu_op    = 2'b01;
      e.pc_target = m_ir[3:0];
      e.imm       = m_ir[3:0];
      e.retired   = 8'(m_ret);
      e.halted    = m_halt;
      if (m_busy) begin
         case (m_ir[7:4])
            4'h1: begin e.acc_we = 1; e.alu_op = 2'b00; e.pc_inc = 1; end
            4'h2: begin e.acc_we = 1; e.alu_op = 2'b01; e.pc_inc = 1; end
            4'h3: begin e.acc_we = 1; e.alu_op = 2'b10; e.pc_inc = 1; end
            4'h5: e.pc_load = 1;
            4'h6: if (z) e.pc_load = 1; else e.pc_inc = 1;
            4'h7: if (c) e.pc_load = 1; else e.pc_inc = 1;
            4'h8: begin e.out_we = 1; e.pc_inc = 1; end
            4'hF: ;
            default: e.pc_inc = 1;
         endcase
      end
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, queue the expected outputs, advance the model past the edge.
   task automatic step(input logic rst, input logic r, input logic [7:0] ins, input logic z,
                       input logic c);
      obs_t e;
      @(posedge clk);
      #1;
      reset = rst; run = r; instr = ins; zero_flag = z; carry_flag = c;
      if (rst) begin
         m_busy = 0; m_halt = 0; m_ir = 8'h00; m_ret = 0; pc = 4'h0;
      end
      e = model_out(z, c);
      exp_q.push_back(e);
      if (!rst) begin
         if (e.pc_load) pc = e.pc_target;
         else if (e.pc_inc) pc = pc + 4'd1;
         if (m_halt) begin
         end else if (m_busy) begin
            m_ret  = (m_ret < 255) ? m_ret + 1 : 255;
            m_halt = (m_ir[7:4] == 4'hF);
            m_busy = 0;
         end else if (r) begin
            m_ir   = ins;
            m_busy = 1;
         end
      end
   endtask

   always @(negedge clk) begin
      obs_t a, e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = '{pc_inc, pc_load, pc_target, acc_we, alu_op, imm, out_we, halted, retired};
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got inc=%b ld=%b tgt=%h we=%b op=%b imm=%h out=%b hlt=%b ret=%0d expected inc=%b ld=%b tgt=%h we=%b op=%b imm=%h out=%b hlt=%b ret=%0d",
                     cyc, a.pc_inc, a.pc_load, a.pc_target, a.acc_we, a.alu_op, a.imm, a.out_we,
                     a.halted, a.retired, e.pc_inc, e.pc_load, e.pc_target, e.acc_we, e.alu_op,
                     e.imm, e.out_we, e.halted, e.retired);
         end
         if (pc_inc) n_inc++;
         if (pc_inc && pc_load) chk("inc_and_load_exclusive", 1, 0);
      end
      cyc++;
   end

   initial begin
      logic [3:0] op;
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      rom[0] = 8'h13; rom[1] = 8'h22; rom[2] = 8'h80; rom[3] = 8'hF0;

      // Program from ROM, PC followed by the bench
      step(1, 0, 8'h00, 0, 0);
      n_inc = 0;
      for (int i = 0; i < 10; i++) step(0, 1, rom[pc], 0, 0);
      @(negedge clk); #1;
      chk("prog_pc_inc_count", n_inc, 3);
      chk("prog_retired", int'(retired), 4);
      chk("prog_halted", int'(halted), 1);

      // Halted ignores run; reset from HALT returns to fetch
      step(0, 1, 8'h13, 1, 1);
      step(1, 1, 8'h00, 0, 0);

      // JMP, JZ, JC both ways, illegal opcode
      step(0, 1, 8'h5A, 0, 0); step(0, 1, 8'h00, 0, 0);
      step(0, 1, 8'h67, 0, 0); step(0, 1, 8'h00, 1, 0);
      step(0, 1, 8'h64, 0, 0); step(0, 1, 8'h00, 0, 1);
      step(0, 1, 8'h7C, 0, 0); step(0, 1, 8'h00, 0, 1);
      step(0, 1, 8'h79, 0, 0); step(0, 1, 8'h00, 1, 0);
      step(0, 1, 8'hB5, 0, 0); step(0, 1, 8'h00, 0, 0);

      // Stall in FETCH, then drop run during EXECUTE
      for (int i = 0; i < 5; i++) step(0, 0, 8'h3F, 0, 0);
      step(0, 1, 8'h22, 0, 0); step(0, 0, 8'h00, 0, 0); step(0, 0, 8'h00, 0, 0);

      // Reset during OUT execute
      step(0, 1, 8'h85, 0, 0); step(1, 1, 8'h00, 0, 0);

      // Saturation of the retired count
      for (int i = 0; i < 600; i++) step(0, 1, 8'h00, 0, 0);
      @(negedge clk); #1;
      chk("retired_saturated", int'(retired), 255);

      // Random traffic with occasional resets to escape HALT
      step(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         op = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 99) == 0) || (m_halt && $urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) != 0), {op, 4'($urandom)}, 1'($urandom), 1'($urandom));
      end
      step(0, 0, 8'h00, 0, 0);
      @(negedge clk); #1;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
